cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter CNT_W, 16, width of hit/miss statistic counters.
REQ-002 Parameter TIMEOUT, 64, max cycles waiting for mem_ack before error; 0 disables timeout.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request strobe; sampled only in IDLE.
REQ-006 Port wr  input  1  request type, 1=write, 0=read; latched with start.
REQ-007 Port hit  input  1  tag-compare result from cache array; sampled in LOOKUP.
REQ-008 Port mem_ack  input  1  memory completion strobe for current mem request.
REQ-009 Port clr_stats  input  1  synchronous clear of both statistic counters.
REQ-010 Port ready  output  1  one-cycle pulse: request complete.
REQ-011 Port error  output  1  one-cycle pulse with ready: memory timeout.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port read_enable  output  1  cache data-array read.
REQ-014 Port write_enable  output  1  cache data-array write (refill or write hit).
REQ-015 Port mem_rd_req  output  1  memory line-read request, level, held until mem_ack.
REQ-016 Port mem_wr_req  output  1  memory write-through request, level, held until mem_ack.
REQ-017 Port hit_cnt  output  CNT_W  saturating count of lookups with hit=1.
REQ-018 Port miss_cnt  output  CNT_W  saturating count of lookups with hit=0.

Function
REQ-019 States SHALL be IDLE, LOOKUP, RD_HIT, REFILL, FILL, WR_THRU, WR_DONE, ERR; all outputs except counters are Moore-decoded from the state register only.
REQ-020 IDLE: start=1 -> LOOKUP next cycle, wr latched; start outside IDLE ignored, not queued.
REQ-021 LOOKUP (1 cycle): read&hit -> RD_HIT; read&!hit -> REFILL; write -> WR_THRU, hit latched.
REQ-022 RD_HIT: read_enable=1, ready=1 for one cycle -> IDLE; read-hit latency start-to-ready is 2 cycles.
REQ-023 REFILL: mem_rd_req=1; mem_ack=1 -> FILL; wait counter reaching TIMEOUT without ack -> ERR.
REQ-024 FILL: write_enable=1 one cycle -> RD_HIT (read served from refilled line).
REQ-025 WR_THRU: mem_wr_req=1; mem_ack=1 -> WR_DONE; timeout -> ERR, same rule as REFILL.
REQ-026 WR_DONE: ready=1; write_enable=1 only if latched hit=1 (write no-allocate) -> IDLE.
REQ-027 ERR: ready=1, error=1 one cycle, no cache write -> IDLE.
REQ-028 Wait counter clears on entry to REFILL/WR_THRU; mem_ack in the cycle the count hits TIMEOUT takes precedence over timeout.
REQ-029 mem_ack outside REFILL/WR_THRU SHALL be ignored.
REQ-030 Counters update on the LOOKUP cycle; at all-ones hold (saturate); clr_stats wins over simultaneous increment.
REQ-031 read_enable and write_enable SHALL never be high in the same cycle; mem_rd_req and mem_wr_req likewise.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, wait counter 0, hit_cnt=miss_cnt=0, latched wr/hit 0, every output 0.
REQ-033 Reset mid-REFILL or mid-WR_THRU SHALL drop mem request immediately with no ready pulse; pending transaction discarded.

Structure
REQ-034 Package cache_ctrl_pkg SHALL hold the state enumeration/encoding and default values of CNT_W and TIMEOUT.
REQ-035 One sub-module sat_counter (width-parametrised, inc, clr, saturating) SHALL be instantiated twice for hit_cnt and miss_cnt.
REQ-036 Wait-counter width SHALL be $clog2(TIMEOUT+1), minimum 1.

Verification
REQ-037 Read hit: start=1,wr=0, hit=1 in LOOKUP -> read_enable+ready at cycle 2, hit_cnt 0->1.
REQ-038 Read miss: hit=0, mem_ack after 5 cycles -> mem_rd_req high 5 cycles, write_enable 1 cycle, then read_enable+ready; miss_cnt=1.
REQ-039 Write miss/hit: wr=1, hit=0, ack after 2 cycles -> ready with write_enable=0; repeat hit=1 -> ready with write_enable=1.
REQ-040 Timeout: TIMEOUT=8, no mem_ack -> ERR after 8 wait cycles, ready=error=1 one cycle, busy falls next cycle.
REQ-041 Saturation/clear: CNT_W=2, 5 hits -> hit_cnt=3; clr_stats coincident with a lookup -> 0.
REQ-042 Reset mid-refill: rst asserted at wait cycle 3 -> mem_rd_req=0 same cycle, no ready, next start behaves normally.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the cache controller.
package cache_ctrl_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RD_HIT  = 3'd2,
    ST_REFILL  = 3'd3,
    ST_FILL    = 3'd4,
    ST_WR_THRU = 3'd5,
    ST_WR_DONE = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Wait counter must hold TIMEOUT itself; never narrower than one bit.
  function automatic int wait_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Single-request cache controller: lookup, read refill, write-through with memory timeout.
// All outputs except the statistic counters are decoded from registered state only.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr,
  input  logic             hit,
  input  logic             mem_ack,
  input  logic             clr_stats,
  output logic             ready,
  output logic             error,
  output logic             busy,
  output logic             read_enable,
  output logic             write_enable,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WAIT_W = wait_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_next;
  logic              wr_q, hit_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, wait_last, timeout;

  assign waiting   = (state == ST_REFILL) || (state == ST_WR_THRU);
  // wait_cnt counts completed wait cycles, so the TIMEOUT-th cycle is the last one.
  assign wait_last = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
  assign timeout   = wait_last && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && start) begin
        wr_q <= wr;
      end
      if (state == ST_LOOKUP) begin
        hit_q <= hit;
      end
      if (!waiting) begin
        wait_cnt <= '0;
      end else if (!wait_last && (TIMEOUT != 0)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (wr_q)     state_next = ST_WR_THRU;
        else if (hit) state_next = ST_RD_HIT;
        else          state_next = ST_REFILL;
      end
      ST_RD_HIT:  state_next = ST_IDLE;
      ST_REFILL: begin
        if (mem_ack)      state_next = ST_FILL;
        else if (timeout) state_next = ST_ERR;
      end
      ST_FILL:    state_next = ST_RD_HIT;
      ST_WR_THRU: begin
        if (mem_ack)      state_next = ST_WR_DONE;
        else if (timeout) state_next = ST_ERR;
      end
      ST_WR_DONE: state_next = ST_IDLE;
      ST_ERR:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign ready        = (state == ST_RD_HIT) || (state == ST_WR_DONE) || (state == ST_ERR);
  assign error        = (state == ST_ERR);
  assign read_enable  = (state == ST_RD_HIT);
  // Write no-allocate: a write miss only goes to memory.
  assign write_enable = (state == ST_FILL) || ((state == ST_WR_DONE) && hit_q);
  assign mem_rd_req   = (state == ST_REFILL);
  assign mem_wr_req   = (state == ST_WR_THRU);

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state == ST_LOOKUP) && hit),
    .clr (clr_stats),
    .cnt (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state == ST_LOOKUP) && !hit),
    .clr (clr_stats),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl built with CNT_W=2, TIMEOUT=8.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, wr = 1'b0, hit = 1'b0, mem_ack = 1'b0, clr_stats = 1'b0;
  logic       ready, error, busy, read_enable, write_enable, mem_rd_req, mem_wr_req;
  logic [1:0] hit_cnt, miss_cnt;

  int tests_run = 0;
  int fails = 0;

  cache_ctrl #(.CNT_W(2), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .wr           (wr),
    .hit          (hit),
    .mem_ack      (mem_ack),
    .clr_stats    (clr_stats),
    .ready        (ready),
    .error        (error),
    .busy         (busy),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are checked 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({ready, error, busy, read_enable, write_enable, mem_rd_req, mem_wr_req, hit_cnt, miss_cnt} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b exp all zero",
               {ready, error, busy, read_enable, write_enable, mem_rd_req, mem_wr_req, hit_cnt, miss_cnt});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b exp 0", busy); end
  endtask

  task automatic test_read_hit();
    start = 1'b1; wr = 1'b0;
    tick();                                   // LOOKUP
    hit = 1'b1;                               // start stays high: must be ignored
    tests_run++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      fails++; $display("FAIL rh_lookup: busy=%b ready=%b exp 1 0", busy, ready);
    end
    tick();                                   // RD_HIT, 2 cycles after start
    start = 1'b0; hit = 1'b0;
    tests_run++;
    if (read_enable !== 1'b1 || ready !== 1'b1 || write_enable !== 1'b0) begin
      fails++; $display("FAIL rh_ready: re=%b ready=%b we=%b exp 1 1 0", read_enable, ready, write_enable);
    end
    tests_run++;
    if (hit_cnt !== 2'd1 || miss_cnt !== 2'd0) begin
      fails++; $display("FAIL rh_cnt: hit=%0d miss=%0d exp 1 0", hit_cnt, miss_cnt);
    end
    tick();                                   // IDLE
    tick();
    tests_run++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL rh_no_queue: busy=%b ready=%b exp 0 0", busy, ready);
    end
  endtask

  task automatic test_read_miss();
    int req_cycles = 0;
    start = 1'b1; wr = 1'b0;
    tick();                                   // LOOKUP
    start = 1'b0; hit = 1'b0;
    tick();                                   // REFILL cycle 1
    for (int i = 1; i <= 5; i++) begin
      if (mem_rd_req === 1'b1 && mem_wr_req === 1'b0) req_cycles++;
      mem_ack = (i == 5);
      tick();
    end
    mem_ack = 1'b0;
    tests_run++;
    if (req_cycles != 5) begin fails++; $display("FAIL rm_req_len: got %0d exp 5", req_cycles); end
    tests_run++;                              // FILL
    if (write_enable !== 1'b1 || read_enable !== 1'b0 || mem_rd_req !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL rm_fill: we=%b re=%b rd=%b ready=%b exp 1 0 0 0",
                        write_enable, read_enable, mem_rd_req, ready);
    end
    tick();                                   // RD_HIT
    tests_run++;
    if (read_enable !== 1'b1 || ready !== 1'b1 || write_enable !== 1'b0) begin
      fails++; $display("FAIL rm_ready: re=%b ready=%b we=%b exp 1 1 0", read_enable, ready, write_enable);
    end
    tests_run++;
    if (miss_cnt !== 2'd1 || hit_cnt !== 2'd1) begin
      fails++; $display("FAIL rm_cnt: hit=%0d miss=%0d exp 1 1", hit_cnt, miss_cnt);
    end
    tick();
  endtask

  task automatic test_write(input logic h, input logic exp_we, input logic [1:0] exp_hit, input logic [1:0] exp_miss);
    start = 1'b1; wr = 1'b1;
    tick();                                   // LOOKUP; stray ack here must be ignored
    start = 1'b0; wr = 1'b0; hit = h; mem_ack = 1'b1;
    tick();                                   // WR_THRU cycle 1
    hit = 1'b0; mem_ack = 1'b0;
    tests_run++;
    if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL wr_req_h%0d: wr=%b rd=%b ready=%b exp 1 0 0", h, mem_wr_req, mem_rd_req, ready);
    end
    tick();                                   // WR_THRU cycle 2
    mem_ack = 1'b1;
    tick();                                   // WR_DONE
    mem_ack = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || write_enable !== exp_we || mem_wr_req !== 1'b0 || read_enable !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL wr_done_h%0d: ready=%b we=%b wrq=%b re=%b err=%b exp 1 %b 0 0 0",
                        h, ready, write_enable, mem_wr_req, read_enable, error, exp_we);
    end
    tests_run++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      fails++; $display("FAIL wr_cnt_h%0d: hit=%0d miss=%0d exp %0d %0d", h, hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    start = 1'b1; wr = 1'b0;
    tick();
    start = 1'b0; hit = 1'b0;
    tick();                                   // REFILL cycle 1
    for (int i = 1; i <= 8; i++) begin
      if (mem_rd_req === 1'b1 && error === 1'b0) req_cycles++;
      tick();
    end
    tests_run++;
    if (req_cycles != 8) begin fails++; $display("FAIL to_req_len: got %0d exp 8", req_cycles); end
    tests_run++;
    if (ready !== 1'b1 || error !== 1'b1 || mem_rd_req !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL to_err: ready=%b err=%b rd=%b we=%b busy=%b exp 1 1 0 0 1",
                        ready, error, mem_rd_req, write_enable, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || ready !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL to_idle: busy=%b ready=%b err=%b exp 0 0 0", busy, ready, error);
    end
  endtask

  task automatic test_ack_at_timeout();
    start = 1'b1; wr = 1'b0;
    tick();
    start = 1'b0; hit = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      mem_ack = (i == 8);
      tick();
    end
    mem_ack = 1'b0;
    tests_run++;
    if (write_enable !== 1'b1 || error !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL ack_edge_fill: we=%b err=%b ready=%b exp 1 0 0", write_enable, error, ready);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1 || read_enable !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL ack_edge_ready: ready=%b re=%b err=%b exp 1 1 0", ready, read_enable, error);
    end
    tick();
  endtask

  task automatic test_saturation();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    tests_run++;
    if (hit_cnt !== 2'd0 || miss_cnt !== 2'd0) begin
      fails++; $display("FAIL sat_clear: hit=%0d miss=%0d exp 0 0", hit_cnt, miss_cnt);
    end
    for (int n = 0; n < 5; n++) begin
      start = 1'b1; wr = 1'b0;
      tick();
      start = 1'b0; hit = 1'b1;
      tick();
      hit = 1'b0;
      tick();
    end
    tests_run++;
    if (hit_cnt !== 2'd3) begin fails++; $display("FAIL sat_hold: hit=%0d exp 3", hit_cnt); end
    start = 1'b1;
    tick();                                   // LOOKUP with simultaneous clear
    start = 1'b0; hit = 1'b1; clr_stats = 1'b1;
    tick();
    hit = 1'b0; clr_stats = 1'b0;
    tests_run++;
    if (hit_cnt !== 2'd0 || ready !== 1'b1) begin
      fails++; $display("FAIL sat_clr_wins: hit=%0d ready=%b exp 0 1", hit_cnt, ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    int ready_seen = 0;
    start = 1'b1; wr = 1'b0;
    tick();
    start = 1'b0; hit = 1'b0;
    tick();                                   // wait cycle 1
    tick();                                   // wait cycle 2
    tick();                                   // wait cycle 3
    tests_run++;
    if (mem_rd_req !== 1'b1) begin fails++; $display("FAIL rst_pre: rd=%b exp 1", mem_rd_req); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_rd_req !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || miss_cnt !== 2'd0) begin
      fails++; $display("FAIL rst_async: rd=%b busy=%b ready=%b miss=%0d exp 0 0 0 0",
                        mem_rd_req, busy, ready, miss_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rst = 1'b0;
      tick();
      if (ready !== 1'b0) ready_seen++;
    end
    tests_run++;
    if (ready_seen != 0) begin fails++; $display("FAIL rst_no_ready: got %0d pulses exp 0", ready_seen); end
    start = 1'b1; wr = 1'b0;
    tick();
    start = 1'b0; hit = 1'b1;
    tick();
    hit = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || read_enable !== 1'b1 || hit_cnt !== 2'd1) begin
      fails++; $display("FAIL rst_recover: ready=%b re=%b hit=%0d exp 1 1 1", ready, read_enable, hit_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write(1'b0, 1'b0, 2'd1, 2'd2);
    test_write(1'b1, 1'b1, 2'd2, 2'd2);
    test_timeout();
    test_ack_at_timeout();
    test_saturation();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
